// File: rtl/shad_flag_stack.sv
// shad_flag_stack: LIFO of WIDTH-bit flag snapshots for nested interrupts.
// PUSH saves the live flags on interrupt entry, POP discards the top entry on
// return; OUT presents the top snapshot (zero when empty) to the restore mux.
// Build option: define SHAD_WRAP_EN to make a push-when-full overwrite the
// oldest entry (circular buffer) instead of being dropped with ERR set.
module shad_flag_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [WIDTH-1:0]             IN,
  input  logic                         PUSH,
  input  logic                         POP,
  input  logic                         ERR_CLR,
  output logic [WIDTH-1:0]             OUT,
  output logic [$clog2(DEPTH+1)-1:0]   CNT,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         ERR
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] LP_LAST  = PW'(DEPTH - 1);

  // Entry storage and bookkeeping. r_wp is the next write slot; the top of
  // stack sits one slot below it, modulo DEPTH. When full, r_wp also points
  // at the oldest entry, which is what a wrapping push overwrites.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [PW-1:0]    w_top;
  logic [PW-1:0]    w_wp_inc;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_wp_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_err_set;

  // Status decodes and modulo-DEPTH pointer neighbours.
  always_comb begin
    w_full   = (r_cnt == LP_DEPTH);
    w_empty  = (r_cnt == '0);
    w_top    = (r_wp == '0)     ? LP_LAST : r_wp - PW'(1);
    w_wp_inc = (r_wp == LP_LAST) ? '0     : r_wp + PW'(1);
  end

  // Operation decode: selects write slot, next pointer/count and error event.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_wp;
    w_wp_nxt  = r_wp;
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    unique case ({PUSH, POP})
      2'b10: begin
        if (!w_full) begin
          w_wr_en   = 1'b1;
          w_wp_nxt  = w_wp_inc;
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
`ifdef SHAD_WRAP_EN
          w_wr_en   = 1'b1;
          w_wp_nxt  = w_wp_inc;
`else
          w_err_set = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_wp_nxt  = w_top;
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_err_set = 1'b1;
        end
      end
      2'b11: begin
        // Replace-top when something is stored; on an empty stack there is
        // no top to replace, so it degenerates to a plain push.
        w_wr_en = 1'b1;
        if (w_empty) begin
          w_wp_nxt  = w_wp_inc;
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_wr_idx  = w_top;
        end
      end
      default: ;
    endcase
  end

  // Entry array: cleared on reset, single write port otherwise.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= IN;
    end
  end

  // Pointer, count and sticky error; an error event beats ERR_CLR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wp  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_wp  <= w_wp_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_err <= 1'b0;
      end
    end
  end

  // Output decodes of registered state.
  always_comb begin
    OUT   = w_empty ? '0 : r_mem[w_top];
    CNT   = r_cnt;
    FULL  = w_full;
    EMPTY = w_empty;
    ERR   = r_err;
  end

endmodule

// File: doc/shad_flag_stack.md
Name: shad_flag_stack

Overview:
- Parametrised successor to the single-entry load-enabled shadow flag register.
- LIFO stack of WIDTH-bit flag snapshots. Supports nested interrupts: each interrupt entry pushes the live flags, and each return-from-interrupt pops them.
- Sits beside the CPU flag registers (C, Z, ...). The control unit drives PUSH/POP; OUT feeds the flag restore mux.

Parameters:
- WIDTH, 2, number of flag bits per snapshot.
- DEPTH, 4, maximum nesting depth (number of entries); legal range 2..16.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
- IN  input  WIDTH  live flag values to save.
- PUSH  input  1  save IN on this edge (was LD).
- POP  input  1  discard the top entry on this edge.
- ERR_CLR  input  1  clears the sticky ERR flag.
- OUT  output  WIDTH  top-of-stack snapshot; all zeros when empty.
- CNT  output  $clog2(DEPTH+1)  number of valid entries.
- FULL  output  1  CNT == DEPTH.
- EMPTY  output  1  CNT == 0.
- ERR  output  1  sticky overflow/underflow indicator.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is synchronous and active-low. All state changes occur on rising CLK only.
- Reset (RST_N=0 at an edge):
  - CNT=0, EMPTY=1, FULL=0, ERR=0, OUT=0.
  - Stored entries are cleared to 0.
  - Reset overrides PUSH/POP/ERR_CLR in the same cycle, including mid-nesting.
- Outputs: OUT, FULL and EMPTY are combinational decodes of registered state (entry array, pointer, CNT). No extra pipeline stage.
- Push only (PUSH=1, POP=0, not full): entry[CNT] <= IN and CNT <= CNT+1. OUT equals that IN in the cycle after the edge.
- Pop only (PUSH=0, POP=1, not empty): CNT <= CNT-1. OUT shows the previous entry the cycle after, or 0 if the stack is now empty. The popped entry's content is don't-care.
- PUSH=1, POP=1, not empty: top entry replaced with IN, CNT unchanged, no error.
- PUSH=1, POP=1, empty: behaves as push only, no error.
- Pop when empty: no state change except ERR <= 1.
- Push only when full: see Optional Feature.
- ERR:
  - Set on any error event.
  - ERR_CLR=1 clears it on the next edge.
  - If an error event and ERR_CLR occur in the same cycle, set wins (ERR=1).
- Width rules:
  - CNT never exceeds DEPTH and never goes below 0.
  - Internal pointer arithmetic is modulo DEPTH.
  - OUT is exactly WIDTH bits, with no sign or zero extension.
- X handling: PUSH/POP are ignored (treated as 0) while RST_N=0.

Optional Feature:
- Macro: SHAD_WRAP_EN.
- Defined: the stack is a circular buffer. A push when full overwrites the oldest entry; CNT stays DEPTH and ERR is not set. Pop-when-empty still sets ERR.
- Undefined: a push when full is ignored. The entries and CNT are unchanged and ERR <= 1.
- Both builds: push+pop when full is a legal top replace and never an error.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with PUSH=1 and IN=2'b11 -> CNT=0, EMPTY=1, OUT=2'b00, ERR=0.
- Nesting: push 2'b01, then 2'b10, then 2'b11 -> OUT=11, CNT=3. Then pop x3 -> OUT=10, 01, 00 on successive cycles; EMPTY=1 after the third pop; ERR=0.
- Overflow (DEPTH=4), pushing 00, 01, 10, 11, then 01:
  - Macro undefined -> the fifth push is ignored; OUT=11, CNT=4, FULL=1, ERR=1. ERR_CLR for one cycle -> ERR=0.
  - Macro defined -> OUT=01, CNT=4, ERR=0. Four pops -> OUT=11, 10, 01, then 00 with EMPTY=1.
- Underflow and ERR priority: pop when empty -> ERR=1, CNT=0. Pop-empty with ERR_CLR=1 in the same cycle -> ERR stays 1.
- Simultaneous ops:
  - Push 2'b01, then PUSH=POP=1 with IN=2'b10 -> CNT=1, OUT=10.
  - Empty stack with PUSH=POP=1 and IN=2'b11 -> CNT=1, OUT=11, ERR=0.
- Reset mid-operation: push 3 entries, assert RST_N=0 for 1 cycle with POP=1 -> CNT=0, OUT=00, ERR=0. The next push of 2'b10 -> OUT=10, CNT=1.
